// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels and data width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: one start bit, eight data bits LSB first, one stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    state_t                 state;
    logic [BAUD_W-1:0]      baud;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   baud_end;

    assign baud_end = (baud == BAUD_LAST);

    // done is looked ahead one cycle so it coincides with the last stop-bit cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= IDLE_LVL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == STOP) && (baud == BAUD_PRE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= START;
                        baud  <= '0;
                        shift <= data;
                        tx    <= START_LVL;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            tx    <= STOP_LVL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        state <= IDLE;
                        baud  <= '0;
                        tx    <= IDLE_LVL;
                        busy  <= 1'b0;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-message locking in front of a shared UART transmitter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    logic [PTR_W-1:0] last_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;
    logic             locked;
    logic             found;
    logic [TO_W-1:0]  idle_cnt;
    logic [7:0]       pick_data;
    logic             done;

    // Accept selection: locked owner only, else first valid after last_ptr
    always_comb begin
        pick  = last_ptr;
        cand  = '0;
        found = 1'b0;
        if (!busy && !rst) begin
            if (locked) begin
                pick  = owner;
                found = req_valid[owner];
            end else begin
                for (int unsigned k = 1; k <= NREQ; k++) begin
                    cand = PTR_W'((32'(last_ptr) + k) % NREQ);
                    if (!found && req_valid[cand]) begin
                        pick  = cand;
                        found = 1'b1;
                    end
                end
            end
        end
        req_ready = found ? (NREQ'(1) << pick) : '0;
        pick_data = req_data[{pick, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            owner    <= '0;
            last_ptr <= PTR_W'(NREQ - 1);
            idle_cnt <= '0;
            grant    <= '0;
        end else if (found) begin
            locked   <= !req_last[pick];
            owner    <= pick;
            last_ptr <= pick;
            idle_cnt <= '0;
            grant    <= NREQ'(1) << pick;
        end else if (locked && !busy && !req_valid[owner]) begin
            // Owner stalled in IDLE: drop the lock after LOCK_TIMEOUT such cycles
            if (idle_cnt == TO_LAST) begin
                locked   <= 1'b0;
                idle_cnt <= '0;
                grant    <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else if (done && !locked) begin
            grant <= '0;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .start(found),
        .data (pick_data),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked each cycle
// against a frame-level model (frame timer, lock/owner, round-robin pointer, stall count).
module tb_uart_tx_arbiter;

    localparam int NREQ  = 2;
    localparam int CPB   = 4;
    localparam int LT    = 20;
    localparam int FRAME = 10 * CPB;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx;
    logic              busy;

    uart_tx_arbiter #(
        .NREQ(NREQ), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pending bytes per requester: {last, data}
    logic [8:0] q [NREQ][$];

    int         m_left, m_owner, m_ptr, m_cnt;
    bit         m_locked;
    logic [9:0] m_bits;
    int         cyc;
    int         acc_cyc[$];
    int         acc_req[$];
    logic [7:0] acc_byte[$];
    int         end_log[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += q[i].size();
        return n;
    endfunction

    task automatic model_reset();
        m_left = 0; m_owner = 0; m_ptr = NREQ - 1; m_cnt = 0; m_locked = 1'b0; m_bits = '1;
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); acc_req.delete(); acc_byte.delete(); end_log.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (q[i].size() != 0);
            {req_last[i], req_data[8*i +: 8]} = (q[i].size() != 0) ? q[i][0] : 9'h000;
        end
    endtask

    // One clock: predict outputs, compare, advance the model across the edge
    task automatic tick();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] eg;
        logic            etx;
        logic [8:0]      item;
        int              c;
        int              sel;
        drive();
        #1;
        er = '0;
        if (m_left == 0) begin
            if (m_locked) begin
                er[m_owner] = req_valid[m_owner];
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (er == '0 && req_valid[(m_ptr + k) % NREQ]) er[(m_ptr + k) % NREQ] = 1'b1;
                end
            end
        end
        etx = (m_left > 0) ? m_bits[(FRAME - m_left) / CPB] : 1'b1;
        eg  = (m_left > 0 || m_locked) ? (NREQ'(1) << m_owner) : '0;
        check("req_ready", 32'(req_ready), 32'(er));
        check("tx", 32'(tx), 32'(etx));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("grant", 32'(grant), 32'(eg));
        c = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (m_left > 0) begin
            if (m_left == 1) end_log.push_back(c);
            m_left--;
        end else if (er != '0) begin
            sel = 0;
            for (int i = 0; i < NREQ; i++) if (er[i]) sel = i;
            item     = q[sel].pop_front();
            m_bits   = {1'b1, item[7:0], 1'b0};
            m_left   = FRAME;
            m_locked = !item[8];
            m_owner  = sel;
            m_ptr    = sel;
            m_cnt    = 0;
            acc_cyc.push_back(c);
            acc_req.push_back(sel);
            acc_byte.push_back(item[7:0]);
        end else if (m_locked && !req_valid[m_owner]) begin
            m_cnt++;
            if (m_cnt == LT) begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() != 0 || m_left != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain", 32'(pending() + m_left), 32'd0);
    endtask

    task automatic tick_until_accept(input int budget);
        int n    = 0;
        int base = acc_byte.size();
        while (acc_byte.size() == base && n < budget) begin
            tick();
            n++;
        end
        check("accept_seen", 32'(acc_byte.size() - base), 32'd1);
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        model_reset();
        drive();
        #2;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();

        // Round-robin: req0 wins first after reset, then alternation
        clear_logs();
        q[0].push_back({1'b1, 8'hAA});
        q[0].push_back({1'b1, 8'hAA});
        q[1].push_back({1'b1, 8'h55});
        drain(400);
        check("rr_byte0", 32'(acc_byte[0]), 32'hAA);
        check("rr_byte1", 32'(acc_byte[1]), 32'h55);
        check("rr_byte2", 32'(acc_byte[2]), 32'hAA);

        // Single byte 0x41
        clear_logs();
        q[0].push_back({1'b1, 8'h41});
        drain(200);
        check("single_req", 32'(acc_req[0]), 32'd0);
        check("single_len", 32'(end_log[0] - acc_cyc[0]), 32'(FRAME));

        // Locked message "HI\n" with req1 waiting
        clear_logs();
        q[0].push_back({1'b0, 8'h48});
        q[0].push_back({1'b0, 8'h49});
        q[0].push_back({1'b1, 8'h0A});
        tick();
        q[1].push_back({1'b0, 8'h31});
        q[1].push_back({1'b1, 8'h31});
        drain(600);
        check("lock_b0", 32'(acc_byte[0]), 32'h48);
        check("lock_b1", 32'(acc_byte[1]), 32'h49);
        check("lock_b2", 32'(acc_byte[2]), 32'h0A);
        check("lock_b3", 32'(acc_byte[3]), 32'h31);
        check("lock_pitch", 32'(acc_cyc[1] - acc_cyc[0]), 32'(FRAME + 1));

        // Timeout: owner stalls after a non-last byte
        clear_logs();
        q[0].push_back({1'b0, 8'h48});
        tick();
        q[1].push_back({1'b1, 8'h32});
        drain(400);
        check("to_byte", 32'(acc_byte[1]), 32'h32);
        check("to_delay", 32'(acc_cyc[1] - end_log[0]), 32'(LT + 1));

        // Back-to-back from req1
        clear_logs();
        q[1].push_back({1'b1, 8'h11});
        q[1].push_back({1'b1, 8'h22});
        q[1].push_back({1'b1, 8'h33});
        q[1].push_back({1'b1, 8'h44});
        drain(400);
        for (int k = 0; k < 3; k++)
            check("b2b_pitch", 32'(acc_cyc[k+1] - acc_cyc[k]), 32'(FRAME + 1));

        // Reset during DATA bit 3 (a 0 bit of 0xA5)
        clear_logs();
        q[0].push_back({1'b1, 8'hA5});
        tick_until_accept(50);
        repeat (4 * CPB + 1) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_reset();
        clear_logs();
        q[0].push_back({1'b1, 8'h7E});
        drain(200);
        check("post_rst_byte", 32'(acc_byte[0]), 32'h7E);
        check("post_rst_req", 32'(acc_req[0]), 32'd0);

        // Random traffic with random message boundaries and owner stalls
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    q[i].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
            end
            tick();
        end
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
